// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID pipeline register of the 5-stage MIPS core.
// Owns pc_F, issues fetches over a req/addr_ok/data_ok bus with a single
// outstanding request, applies decode-resolved redirects (keeping the delay
// slot) and MEM-stage exception redirects, and presents instr_D/pc_D with
// delay-slot and fetch address-error flags to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_F,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic [1:0]  PCSrc_D,
  input  logic        Jump_D,
  input  logic [31:0] pc_branch_D,
  input  logic [31:0] pc_jump_D,
  input  logic [31:0] pc_jr_D,
  input  logic        except_flush_M,
  input  logic [31:0] except_pc_M,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        fetch_stall_F,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic        valid_D,
  output logic        is_in_delayslot_D,
  output logic        except_adel_D
);

  // Fetch bus handshake states.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // request presented, waiting for acceptance
    ST_WAIT = 2'd1,  // request accepted, waiting for data
    ST_HOLD = 2'd2,  // data captured in buffer, F is stalled
    ST_DROP = 2'd3   // cancelled request still outstanding
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic        redir_valid_r;
  logic [31:0] redir_pc_r;
  logic [31:0] buf_r;

  logic        misaligned_s;
  logic        inst_req_s;
  logic        redirect_s;
  logic        slot_pending_s;
  logic [31:0] target_s;
  logic [31:0] seq_pc_s;
  logic [31:0] next_pc_s;
  logic        fetch_done_s;
  logic [31:0] fetch_instr_s;
  logic        fetch_adel_s;
  logic        advance_s;
  logic        dslot_s;
  logic        buf_load_s;

  // Fetch datapath: completion, selected instruction, next PC and redirect decode.
  always_comb begin
    misaligned_s   = (pc_F[1:0] != 2'b00);
    inst_req_s     = 1'b0;
    redirect_s     = (PCSrc_D != 2'b00) & valid_D;
    slot_pending_s = Jump_D & valid_D;
    seq_pc_s       = pc_F + 32'd4;
    target_s       = seq_pc_s;
    fetch_done_s   = 1'b0;
    fetch_instr_s  = 32'h0000_0000;
    fetch_adel_s   = 1'b0;

    if (!rst && (state_r == ST_REQ) && !misaligned_s) begin
      inst_req_s = 1'b1;
    end else begin
      inst_req_s = 1'b0;
    end

    case (PCSrc_D)
      2'b01:   target_s = pc_branch_D;
      2'b10:   target_s = pc_jump_D;
      2'b11:   target_s = pc_jr_D;
      default: target_s = seq_pc_s;
    endcase

    case (state_r)
      ST_REQ: begin
        // A misaligned PC never reaches the bus; it completes as an AdEL.
        fetch_done_s  = misaligned_s;
        fetch_instr_s = 32'h0000_0000;
        fetch_adel_s  = misaligned_s;
      end
      ST_WAIT: begin
        fetch_done_s  = inst_data_ok;
        fetch_instr_s = inst_rdata;
        fetch_adel_s  = 1'b0;
      end
      ST_HOLD: begin
        fetch_done_s  = 1'b1;
        fetch_instr_s = buf_r;
        fetch_adel_s  = 1'b0;
      end
      ST_DROP: begin
        fetch_done_s  = 1'b0;
        fetch_instr_s = 32'h0000_0000;
        fetch_adel_s  = 1'b0;
      end
      default: begin
        fetch_done_s  = 1'b0;
        fetch_instr_s = 32'h0000_0000;
        fetch_adel_s  = 1'b0;
      end
    endcase

    advance_s = fetch_done_s & ~Stall_F;

    // A live redirect in D beats a redirect remembered from a bubble cycle.
    if (redirect_s) begin
      next_pc_s = target_s;
    end else if (redir_valid_r) begin
      next_pc_s = redir_pc_r;
    end else begin
      next_pc_s = seq_pc_s;
    end

    dslot_s    = slot_pending_s | redir_valid_r;
    buf_load_s = (state_r == ST_WAIT) & inst_data_ok & ~advance_s & ~except_flush_M;
  end

  assign inst_req      = inst_req_s;
  assign inst_addr     = pc_F;
  assign fetch_stall_F = ~fetch_done_s;

  // Next-state logic for the fetch handshake; exceptions override everything.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_REQ: begin
        if (except_flush_M) begin
          state_s = (inst_req_s && inst_addr_ok) ? ST_DROP : ST_REQ;
        end else if (inst_req_s && inst_addr_ok) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (except_flush_M) begin
          state_s = inst_data_ok ? ST_REQ : ST_DROP;
        end else if (inst_data_ok) begin
          state_s = advance_s ? ST_REQ : ST_HOLD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (except_flush_M || advance_s) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_DROP: begin
        // The cancelled response is discarded; leave only once it has arrived.
        if (inst_data_ok) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_REQ;
      end
    endcase
  end

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_REQ;
    end else begin
      state_r <= state_s;
    end
  end

  // PC, pending-redirect memory and fetch buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_F          <= RESET_PC;
      redir_valid_r <= 1'b0;
      redir_pc_r    <= 32'h0000_0000;
      buf_r         <= 32'h0000_0000;
    end else begin
      if (except_flush_M) begin
        pc_F          <= except_pc_M;
        redir_valid_r <= 1'b0;
      end else if (advance_s) begin
        pc_F          <= next_pc_s;
        redir_valid_r <= 1'b0;
      end else if (!Stall_D && redirect_s) begin
        // Branch leaves D before its slot is fetched: remember the target.
        redir_valid_r <= 1'b1;
        redir_pc_r    <= target_s;
      end else if (!Stall_D && slot_pending_s) begin
        // Not-taken branch: still remember that the next fetch is a delay slot.
        redir_valid_r <= 1'b1;
        redir_pc_r    <= seq_pc_s;
      end
      if (buf_load_s) begin
        buf_r <= inst_rdata;
      end
    end
  end

  // IF/ID pipeline register: clear, hold, load or insert bubble.
  always_ff @(posedge clk) begin
    if (rst || except_flush_M || Flush_D) begin
      instr_D           <= 32'h0000_0000;
      pc_D              <= 32'h0000_0000;
      valid_D           <= 1'b0;
      is_in_delayslot_D <= 1'b0;
      except_adel_D     <= 1'b0;
    end else if (Stall_D) begin
      instr_D           <= instr_D;
      pc_D              <= pc_D;
      valid_D           <= valid_D;
      is_in_delayslot_D <= is_in_delayslot_D;
      except_adel_D     <= except_adel_D;
    end else if (advance_s) begin
      instr_D           <= fetch_instr_s;
      pc_D              <= pc_F;
      valid_D           <= 1'b1;
      is_in_delayslot_D <= dslot_s;
      except_adel_D     <= fetch_adel_s;
    end else begin
      instr_D           <= 32'h0000_0000;
      pc_D              <= pc_D;
      valid_D           <= 1'b0;
      is_in_delayslot_D <= 1'b0;
      except_adel_D     <= 1'b0;
    end
  end

endmodule
